// File: rtl/spi_csr_bridge.sv
// SPI mode-0 slave that turns command/data frames into CSR register-map accesses.
// Optional feature: define SPI_CSR_AUTOINC_EN to advance addr_o after every data byte of a burst.
module spi_csr_bridge #(
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int WR_HOLD     = 3,
    parameter int RD_HOLD     = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  spi_sclk_i,
    input  logic                  spi_cs_n_i,
    input  logic                  spi_mosi_i,
    output logic                  spi_miso_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] write_data_o,
    output logic                  write_en_o,
    output logic                  read_en_o,
    input  logic [DATA_WIDTH-1:0] read_data_i,
    output logic                  frame_err_o
);

    localparam int BIT_W    = $clog2(DATA_WIDTH);
    localparam int HOLD_MAX = (WR_HOLD > RD_HOLD) ? WR_HOLD : RD_HOLD;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WR_DATA,
        WR_COMMIT,
        RD_FETCH,
        RD_SHIFT
    } state_t;

    state_t                  r_state;
    logic [SYNC_STAGES-1:0]  r_sclkSync;
    logic [SYNC_STAGES-1:0]  r_csSync;
    logic [SYNC_STAGES-1:0]  r_mosiSync;
    logic                    r_sclkPrev;
    logic                    r_csPrev;
    logic [DATA_WIDTH-2:0]   r_rxShift;
    logic [BIT_W-1:0]        r_bitCnt;
    logic [DATA_WIDTH-1:0]   r_txShift;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_writeData;
    logic                    r_writeEn;
    logic                    r_readEn;
    logic [HOLD_W-1:0]       r_holdCnt;
    logic                    r_csEndPend;
    logic                    r_frameErr;

    logic                    w_sclk;
    logic                    w_csN;
    logic                    w_mosi;
    logic                    w_csFall;
    logic                    w_csRise;
    logic                    w_sclkRise;
    logic                    w_sclkFall;
    logic                    w_shiftEn;
    logic                    w_lastBit;
    logic                    w_byteDone;
    logic [DATA_WIDTH-1:0]   w_rxByte;
    logic [ADDR_WIDTH-1:0]   w_nextAddr;

    // Synchronizers are deliberately not reset so edge detection right after
    // rst_i reflects the real pin levels and no false cs_n edge is seen.
    always_ff @(posedge clk_i) begin
        r_sclkSync <= {r_sclkSync[SYNC_STAGES-2:0], spi_sclk_i};
        r_csSync   <= {r_csSync[SYNC_STAGES-2:0], spi_cs_n_i};
        r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], spi_mosi_i};
        r_sclkPrev <= w_sclk;
        r_csPrev   <= w_csN;
    end

    assign w_sclk     = r_sclkSync[SYNC_STAGES-1];
    assign w_csN      = r_csSync[SYNC_STAGES-1];
    assign w_mosi     = r_mosiSync[SYNC_STAGES-1];
    assign w_csFall   = r_csPrev & ~w_csN;
    assign w_csRise   = ~r_csPrev & w_csN;
    assign w_sclkRise = w_sclk & ~r_sclkPrev & ~w_csN;
    assign w_sclkFall = ~w_sclk & r_sclkPrev & ~w_csN;

    assign w_shiftEn  = w_sclkRise && ((r_state == CMD) || (r_state == WR_DATA) || (r_state == RD_SHIFT));
    assign w_lastBit  = (r_bitCnt == BIT_W'(DATA_WIDTH - 1));
    assign w_byteDone = w_shiftEn && w_lastBit;
    assign w_rxByte   = {r_rxShift, w_mosi};

`ifdef SPI_CSR_AUTOINC_EN
    assign w_nextAddr = r_addr + ADDR_WIDTH'(1);
`else
    assign w_nextAddr = r_addr;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rxShift <= '0;
            r_bitCnt  <= '0;
        end else if (w_csRise || (r_state == IDLE)) begin
            r_bitCnt <= '0;
        end else if (w_shiftEn) begin
            r_rxShift <= w_rxByte[DATA_WIDTH-2:0];
            r_bitCnt  <= w_lastBit ? '0 : r_bitCnt + BIT_W'(1);
        end
    end

    // A cs_n rise aborts every state except WR_COMMIT, which finishes its
    // strobe first so a fully received byte is never half-written.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_txShift   <= '0;
            r_addr      <= '0;
            r_writeData <= '0;
            r_writeEn   <= 1'b0;
            r_readEn    <= 1'b0;
            r_holdCnt   <= '0;
            r_csEndPend <= 1'b0;
            r_frameErr  <= 1'b0;
        end else if (w_csRise && (r_state != IDLE) && (r_state != WR_COMMIT)) begin
            r_state   <= IDLE;
            r_readEn  <= 1'b0;
            r_txShift <= '0;
            if (r_bitCnt != '0) begin
                r_frameErr <= 1'b1;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    r_txShift <= '0;
                    if (w_csFall) begin
                        r_state <= CMD;
                    end
                end
                CMD: begin
                    if (w_byteDone) begin
                        r_addr <= w_rxByte[ADDR_WIDTH-1:0];
                        if (w_rxByte[DATA_WIDTH-1]) begin
                            r_state   <= RD_FETCH;
                            r_readEn  <= 1'b1;
                            r_holdCnt <= '0;
                        end else begin
                            r_state <= WR_DATA;
                        end
                    end
                end
                WR_DATA: begin
                    if (w_byteDone) begin
                        r_writeData <= w_rxByte;
                        r_writeEn   <= 1'b1;
                        r_holdCnt   <= '0;
                        r_state     <= WR_COMMIT;
                    end
                end
                WR_COMMIT: begin
                    if (w_csRise) begin
                        r_csEndPend <= 1'b1;
                    end
                    if (r_holdCnt == HOLD_W'(WR_HOLD - 1)) begin
                        r_writeEn <= 1'b0;
                        r_addr    <= w_nextAddr;
                        r_holdCnt <= '0;
                        if (r_csEndPend || w_csRise) begin
                            r_state     <= IDLE;
                            r_csEndPend <= 1'b0;
                        end else begin
                            r_state <= WR_DATA;
                        end
                    end else begin
                        r_holdCnt <= r_holdCnt + HOLD_W'(1);
                    end
                end
                RD_FETCH: begin
                    if (r_readEn) begin
                        if (r_holdCnt == HOLD_W'(RD_HOLD - 1)) begin
                            r_readEn <= 1'b0;
                        end else begin
                            r_holdCnt <= r_holdCnt + HOLD_W'(1);
                        end
                    end else begin
                        r_txShift <= read_data_i;
                        r_state   <= RD_SHIFT;
                    end
                end
                RD_SHIFT: begin
                    // The MSB is already on MISO after the fetch, so only
                    // falls that follow a rise within this byte shift.
                    if (w_byteDone) begin
                        r_addr    <= w_nextAddr;
                        r_readEn  <= 1'b1;
                        r_holdCnt <= '0;
                        r_state   <= RD_FETCH;
                    end else if (w_sclkFall && (r_bitCnt != '0)) begin
                        r_txShift <= {r_txShift[DATA_WIDTH-2:0], 1'b0};
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign spi_miso_o   = r_txShift[DATA_WIDTH-1];
    assign addr_o       = r_addr;
    assign write_data_o = r_writeData;
    assign write_en_o   = r_writeEn;
    assign read_en_o    = r_readEn;
    assign frame_err_o  = r_frameErr;

    strobeExclusive: assert property (@(posedge clk_i) !(r_writeEn && r_readEn));

endmodule

// File: tb/tb_spi_csr_bridge.sv
// Directed bench for spi_csr_bridge: bit-banged SPI master plus a small register-map model.
// Expected addresses of burst tests follow SPI_CSR_AUTOINC_EN.
module tb_spi_csr_bridge;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       spiSclk = 1'b0;
    logic       spiCsN = 1'b1;
    logic       spiMosi = 1'b0;
    logic       spiMiso;
    logic [6:0] addrO;
    logic [7:0] writeDataO;
    logic       writeEnO;
    logic       readEnO;
    logic [7:0] readDataI;
    logic       frameErrO;

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        logic [6:0] addr;
        logic [7:0] data;
        int         len;
        bit         stable;
    } access_t;

    access_t    wrLog[$];
    access_t    rdLog[$];
    logic [7:0] regs [0:127];
    int         wrLen = 0;
    int         rdLen = 0;
    int         bothHigh = 0;
    access_t    wrCur;
    access_t    rdCur;

    spi_csr_bridge dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .spi_sclk_i   (spiSclk),
        .spi_cs_n_i   (spiCsN),
        .spi_mosi_i   (spiMosi),
        .spi_miso_o   (spiMiso),
        .addr_o       (addrO),
        .write_data_o (writeDataO),
        .write_en_o   (writeEnO),
        .read_en_o    (readEnO),
        .read_data_i  (readDataI),
        .frame_err_o  (frameErrO)
    );

    always #5 clk_i = ~clk_i;

    // Register map: reg0 = 0xCC and reg 0x20 = 0xA5 after reset, others hold their index.
    always @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 128; i++) regs[i] <= 8'(i);
            regs[0]     <= 8'hCC;
            regs[7'h20] <= 8'hA5;
        end else if (writeEnO) begin
            regs[addrO] <= writeDataO;
        end
    end

    assign readDataI = regs[addrO];

    // Strobe monitor: records length and address/data stability of each pulse.
    always @(negedge clk_i) begin
        if (writeEnO && readEnO) bothHigh++;
        if (rst_i) begin
            wrLen = 0;
            rdLen = 0;
        end else begin
            if (writeEnO) begin
                if (wrLen == 0) begin
                    wrCur.addr = addrO; wrCur.data = writeDataO; wrCur.stable = 1'b1;
                end else if (addrO !== wrCur.addr || writeDataO !== wrCur.data) begin
                    wrCur.stable = 1'b0;
                end
                wrLen++;
            end else if (wrLen != 0) begin
                wrCur.len = wrLen;
                wrLog.push_back(wrCur);
                wrLen = 0;
            end
            if (readEnO) begin
                if (rdLen == 0) begin
                    rdCur.addr = addrO; rdCur.data = 8'h00; rdCur.stable = 1'b1;
                end else if (addrO !== rdCur.addr) begin
                    rdCur.stable = 1'b0;
                end
                rdLen++;
            end else if (rdLen != 0) begin
                rdCur.len = rdLen;
                rdLog.push_back(rdCur);
                rdLen = 0;
            end
        end
    end

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic csLow();
        spiCsN = 1'b0;
        waitClk(8);
    endtask

    task automatic csHigh();
        waitClk(8);
        spiCsN = 1'b1;
        waitClk(16);
    endtask

    // SCLK half period is 8 clocks; MISO is sampled at each rising edge.
    task automatic spiXfer(input logic [7:0] tx, input int nbits, input bit earlyCs, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            spiMosi = tx[i];
            waitClk(8);
            spiSclk = 1'b1;
            rx[i] = spiMiso;
            if (earlyCs && i == 8 - nbits) begin
                waitClk(1);
                spiCsN = 1'b1;
            end
            waitClk(8);
            spiSclk = 1'b0;
        end
    endtask

    task automatic frame2(input logic [7:0] b0, input logic [7:0] b1, output logic [7:0] rx1);
        logic [7:0] dummy;
        csLow();
        spiXfer(b0, 8, 1'b0, dummy);
        spiXfer(b1, 8, 1'b0, rx1);
        csHigh();
    endtask

    task automatic doReset();
        rst_i = 1'b1;
        waitClk(5);
        rst_i = 1'b0;
        waitClk(4);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        waitClk(5);
        testsRun++; if (addrO !== 7'h00) begin testsFailed++; $display("[TB] FAIL reset_addr: got %h expected 00", addrO); end
        testsRun++; if (writeDataO !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_wdata: got %h expected 00", writeDataO); end
        testsRun++; if (writeEnO !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_wen: got %b expected 0", writeEnO); end
        testsRun++; if (readEnO !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_ren: got %b expected 0", readEnO); end
        testsRun++; if (spiMiso !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_miso: got %b expected 0", spiMiso); end
        testsRun++; if (frameErrO !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_ferr: got %b expected 0", frameErrO); end
        rst_i = 1'b0;
        waitClk(4);
    endtask

    task automatic test_write_single();
        logic [7:0] rx;
        wrLog.delete();
        frame2(8'h05, 8'h5A, rx);
        testsRun++; if (wrLog.size() !== 1) begin testsFailed++; $display("[TB] FAIL wr1_count: got %0d expected 1", wrLog.size()); end
        if (wrLog.size() >= 1) begin
            testsRun++; if (wrLog[0].addr !== 7'h05) begin testsFailed++; $display("[TB] FAIL wr1_addr: got %h expected 05", wrLog[0].addr); end
            testsRun++; if (wrLog[0].data !== 8'h5A) begin testsFailed++; $display("[TB] FAIL wr1_data: got %h expected 5a", wrLog[0].data); end
            testsRun++; if (wrLog[0].len !== 3) begin testsFailed++; $display("[TB] FAIL wr1_len: got %0d expected 3", wrLog[0].len); end
            testsRun++; if (wrLog[0].stable !== 1'b1) begin testsFailed++; $display("[TB] FAIL wr1_stable: got %b expected 1", wrLog[0].stable); end
        end
        testsRun++; if (regs[5] !== 8'h5A) begin testsFailed++; $display("[TB] FAIL wr1_reg5: got %h expected 5a", regs[5]); end
        frame2(8'h85, 8'h00, rx);
        testsRun++; if (rx !== 8'h5A) begin testsFailed++; $display("[TB] FAIL wr1_readback: got %h expected 5a", rx); end
        testsRun++; if (spiMiso !== 1'b0) begin testsFailed++; $display("[TB] FAIL wr1_miso_idle: got %b expected 0", spiMiso); end
        testsRun++; if (frameErrO !== 1'b0) begin testsFailed++; $display("[TB] FAIL wr1_ferr: got %b expected 0", frameErrO); end
    endtask

    task automatic test_read_after_reset();
        logic [7:0] rx;
        logic [6:0] expNext;
`ifdef SPI_CSR_AUTOINC_EN
        expNext = 7'h01;
`else
        expNext = 7'h00;
`endif
        doReset();
        rdLog.delete();
        frame2(8'h80, 8'h00, rx);
        testsRun++; if (rx !== 8'hCC) begin testsFailed++; $display("[TB] FAIL rd_data: got %h expected cc", rx); end
        testsRun++; if (rdLog.size() !== 2) begin testsFailed++; $display("[TB] FAIL rd_count: got %0d expected 2", rdLog.size()); end
        if (rdLog.size() >= 2) begin
            testsRun++; if (rdLog[0].addr !== 7'h00) begin testsFailed++; $display("[TB] FAIL rd_addr: got %h expected 00", rdLog[0].addr); end
            testsRun++; if (rdLog[0].len !== 3) begin testsFailed++; $display("[TB] FAIL rd_len: got %0d expected 3", rdLog[0].len); end
            testsRun++; if (rdLog[0].stable !== 1'b1) begin testsFailed++; $display("[TB] FAIL rd_stable: got %b expected 1", rdLog[0].stable); end
            testsRun++; if (rdLog[1].addr !== expNext) begin testsFailed++; $display("[TB] FAIL rd_prefetch_addr: got %h expected %h", rdLog[1].addr, expNext); end
        end
        testsRun++; if (frameErrO !== 1'b0) begin testsFailed++; $display("[TB] FAIL rd_ferr: got %b expected 0", frameErrO); end
    endtask

    task automatic test_burst_wrap();
        logic [7:0] rx;
        logic [6:0] expAddr2;
`ifdef SPI_CSR_AUTOINC_EN
        expAddr2 = 7'h00;
`else
        expAddr2 = 7'h7F;
`endif
        wrLog.delete();
        csLow();
        spiXfer(8'h7F, 8, 1'b0, rx);
        spiXfer(8'h11, 8, 1'b0, rx);
        spiXfer(8'h22, 8, 1'b0, rx);
        csHigh();
        testsRun++; if (wrLog.size() !== 2) begin testsFailed++; $display("[TB] FAIL burst_count: got %0d expected 2", wrLog.size()); end
        if (wrLog.size() >= 2) begin
            testsRun++; if (wrLog[0].addr !== 7'h7F) begin testsFailed++; $display("[TB] FAIL burst_addr0: got %h expected 7f", wrLog[0].addr); end
            testsRun++; if (wrLog[0].data !== 8'h11) begin testsFailed++; $display("[TB] FAIL burst_data0: got %h expected 11", wrLog[0].data); end
            testsRun++; if (wrLog[1].addr !== expAddr2) begin testsFailed++; $display("[TB] FAIL burst_addr1: got %h expected %h", wrLog[1].addr, expAddr2); end
            testsRun++; if (wrLog[1].data !== 8'h22) begin testsFailed++; $display("[TB] FAIL burst_data1: got %h expected 22", wrLog[1].data); end
            testsRun++; if (wrLog[1].len !== 3) begin testsFailed++; $display("[TB] FAIL burst_len1: got %0d expected 3", wrLog[1].len); end
        end
`ifdef SPI_CSR_AUTOINC_EN
        testsRun++; if (regs[7'h7F] !== 8'h11) begin testsFailed++; $display("[TB] FAIL burst_reg7f: got %h expected 11", regs[7'h7F]); end
        testsRun++; if (regs[0] !== 8'h22) begin testsFailed++; $display("[TB] FAIL burst_reg00: got %h expected 22", regs[0]); end
`else
        testsRun++; if (regs[7'h7F] !== 8'h22) begin testsFailed++; $display("[TB] FAIL burst_reg7f: got %h expected 22", regs[7'h7F]); end
        testsRun++; if (regs[0] !== 8'hCC) begin testsFailed++; $display("[TB] FAIL burst_reg00: got %h expected cc", regs[0]); end
`endif
    endtask

    task automatic test_truncated();
        logic [7:0] rx;
        wrLog.delete();
        csLow();
        spiXfer(8'h03, 8, 1'b0, rx);
        spiXfer(8'hAB, 4, 1'b0, rx);
        csHigh();
        testsRun++; if (wrLog.size() !== 0) begin testsFailed++; $display("[TB] FAIL trunc_no_write: got %0d expected 0", wrLog.size()); end
        testsRun++; if (frameErrO !== 1'b1) begin testsFailed++; $display("[TB] FAIL trunc_ferr: got %b expected 1", frameErrO); end
        testsRun++; if (regs[3] !== 8'h03) begin testsFailed++; $display("[TB] FAIL trunc_reg3: got %h expected 03", regs[3]); end
        frame2(8'h06, 8'h77, rx);
        testsRun++; if (wrLog.size() !== 1) begin testsFailed++; $display("[TB] FAIL trunc_next_count: got %0d expected 1", wrLog.size()); end
        if (wrLog.size() >= 1) begin
            testsRun++; if (wrLog[0].addr !== 7'h06 || wrLog[0].data !== 8'h77) begin testsFailed++; $display("[TB] FAIL trunc_next_write: got %h/%h expected 06/77", wrLog[0].addr, wrLog[0].data); end
        end
        testsRun++; if (frameErrO !== 1'b1) begin testsFailed++; $display("[TB] FAIL trunc_sticky: got %b expected 1", frameErrO); end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] rx;
        csLow();
        spiXfer(8'hA0, 8, 1'b0, rx);
        spiXfer(8'h00, 3, 1'b0, rx);
        testsRun++; if (rx[7:5] !== 3'b101) begin testsFailed++; $display("[TB] FAIL rstrd_partial: got %b expected 101", rx[7:5]); end
        rst_i = 1'b1;
        waitClk(1);
        testsRun++; if (spiMiso !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstrd_miso: got %b expected 0", spiMiso); end
        testsRun++; if (addrO !== 7'h00) begin testsFailed++; $display("[TB] FAIL rstrd_addr: got %h expected 00", addrO); end
        testsRun++; if (writeEnO !== 1'b0 || readEnO !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstrd_strobes: got %b%b expected 00", writeEnO, readEnO); end
        testsRun++; if (writeDataO !== 8'h00) begin testsFailed++; $display("[TB] FAIL rstrd_wdata: got %h expected 00", writeDataO); end
        testsRun++; if (frameErrO !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstrd_ferr: got %b expected 0", frameErrO); end
        rst_i = 1'b0;
        spiCsN = 1'b1;
        waitClk(16);
        wrLog.delete();
        frame2(8'h10, 8'h33, rx);
        testsRun++; if (wrLog.size() !== 1) begin testsFailed++; $display("[TB] FAIL rstrd_next_count: got %0d expected 1", wrLog.size()); end
        if (wrLog.size() >= 1) begin
            testsRun++; if (wrLog[0].addr !== 7'h10 || wrLog[0].data !== 8'h33) begin testsFailed++; $display("[TB] FAIL rstrd_next_write: got %h/%h expected 10/33", wrLog[0].addr, wrLog[0].data); end
            testsRun++; if (wrLog[0].len !== 3) begin testsFailed++; $display("[TB] FAIL rstrd_next_len: got %0d expected 3", wrLog[0].len); end
        end
        testsRun++; if (regs[7'h10] !== 8'h33) begin testsFailed++; $display("[TB] FAIL rstrd_reg10: got %h expected 33", regs[7'h10]); end
        testsRun++; if (frameErrO !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstrd_ferr_after: got %b expected 0", frameErrO); end
    endtask

    task automatic test_cs_during_commit();
        logic [7:0] rx;
        wrLog.delete();
        csLow();
        spiXfer(8'h12, 8, 1'b0, rx);
        spiXfer(8'h44, 8, 1'b1, rx);
        waitClk(20);
        testsRun++; if (wrLog.size() !== 1) begin testsFailed++; $display("[TB] FAIL cscommit_count: got %0d expected 1", wrLog.size()); end
        if (wrLog.size() >= 1) begin
            testsRun++; if (wrLog[0].len !== 3) begin testsFailed++; $display("[TB] FAIL cscommit_len: got %0d expected 3", wrLog[0].len); end
            testsRun++; if (wrLog[0].addr !== 7'h12 || wrLog[0].data !== 8'h44) begin testsFailed++; $display("[TB] FAIL cscommit_write: got %h/%h expected 12/44", wrLog[0].addr, wrLog[0].data); end
        end
        testsRun++; if (regs[7'h12] !== 8'h44) begin testsFailed++; $display("[TB] FAIL cscommit_reg12: got %h expected 44", regs[7'h12]); end
        testsRun++; if (frameErrO !== 1'b0) begin testsFailed++; $display("[TB] FAIL cscommit_ferr: got %b expected 0", frameErrO); end
        testsRun++; if (spiMiso !== 1'b0) begin testsFailed++; $display("[TB] FAIL cscommit_miso: got %b expected 0", spiMiso); end
        testsRun++; if (bothHigh !== 0) begin testsFailed++; $display("[TB] FAIL strobe_overlap: got %0d expected 0", bothHigh); end
    endtask

    initial begin
        test_reset();
        test_write_single();
        test_read_after_reset();
        test_burst_wrap();
        test_truncated();
        test_reset_mid_read();
        test_cs_during_commit();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/spi_csr_bridge.md
Name: spi_csr_bridge

Overview:
- SPI slave front end (mode 0, MSB first) that turns serial frames into register-map accesses.
- Drives the register map's addr/write_data/write_en/read_en inputs and returns its read data on MISO.
- Sits directly upstream of the CSR register map, in the same clk_i domain.
- SPI pins are asynchronous: they are oversampled and edge-detected internally. clk_i must be at least 16x SCLK.

Parameters:
- ADDR_WIDTH, 7, register address width; matches the register map.
- DATA_WIDTH, 8, register and SPI data byte width.
- SYNC_STAGES, 2, synchronizer flops on sclk/cs_n/mosi (legal values 2..3).
- WR_HOLD, 3, cycles write_en_o is held per write. The register map needs 3 to pass data through its 2-stage write pipeline.
- RD_HOLD, 3, cycles read_en_o is held before read_data_i is captured.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- spi_sclk_i  in  1  SPI clock, asynchronous
- spi_cs_n_i  in  1  SPI chip select, active-low, asynchronous
- spi_mosi_i  in  1  SPI data in
- spi_miso_o  out  1  SPI data out
- addr_o  out  ADDR_WIDTH  register address
- write_data_o  out  DATA_WIDTH  write data
- write_en_o  out  1  write strobe
- read_en_o  out  1  read strobe
- read_data_i  in  DATA_WIDTH  register read data
- frame_err_o  out  1  sticky flag; set on a truncated frame, cleared only by rst_i

Behaviour:
Frame format:
- Byte 0 is the command: bit7 = 1 read / 0 write; bits[ADDR_WIDTH-1:0] = address (bits above ADDR_WIDTH-1 ignored).
- Bytes 1..N are data.
- MOSI is sampled on synchronized SCLK rising edges; MISO changes on falling edges.

Reset:
- Clock and reset ports are clk_i and rst_i; one clock; reset is synchronous and active-high.
- On rst_i: addr_o=0, write_data_o=0, write_en_o=0, read_en_o=0, spi_miso_o=0, frame_err_o=0.
- Bit counter is cleared and the FSM returns to IDLE.
- Reset mid-frame discards the frame. The bridge resynchronizes on the next cs_n falling edge.

State machine (IDLE, CMD, WR_DATA, WR_COMMIT, RD_FETCH, RD_SHIFT):
- IDLE -> CMD on a synchronized cs_n falling edge. Bit counter is cleared.
- CMD: shift 8 bits.
  - On the 8th rising edge, latch addr_o.
  - Go to RD_FETCH if bit7=1, otherwise WR_DATA.
- WR_DATA: shift 8 bits. On the 8th edge, latch write_data_o and go to WR_COMMIT.
- WR_COMMIT: assert write_en_o for exactly WR_HOLD consecutive cycles.
  - addr_o and write_data_o stay stable throughout.
  - Then advance the address (see Optional Feature) and return to WR_DATA.
- RD_FETCH: assert read_en_o for RD_HOLD cycles with addr_o stable.
  - On the cycle after read_en_o drops, load read_data_i into the TX shift register.
  - Drive its MSB on spi_miso_o, then go to RD_SHIFT.
- RD_SHIFT: shift TX out on falling SCLK edges. After the 8th rising edge:
  - advance the address;
  - re-enter RD_FETCH to prefetch the next byte;
  - this supports bursts.
- Worst-case latency from the 8th SCLK rise to MISO valid is SYNC_STAGES + 1 + RD_HOLD + 1 = 7 cycles. This is under half an SCLK period at 16x.

cs_n rising edge (any state):
- Return to IDLE.
- If the bit counter is not 0, set frame_err_o.
- A commit already in progress (WR_COMMIT) completes its full WR_HOLD cycles before IDLE.
- A partial data byte is never written.

General rules:
- write_en_o and read_en_o are never high together.
- spi_miso_o = 0 whenever cs_n is high.
- SCLK edges seen while cs_n is high are ignored.

Optional Feature:
- Macro: SPI_CSR_AUTOINC_EN.
- Defined: after each data byte, addr_o increments modulo 2^ADDR_WIDTH (0x7F wraps to 0x00), so a burst covers consecutive registers.
- Undefined: addr_o is unchanged across a burst; every data byte targets the command address (FIFO-style repeated access).

Test Plan:
1. Write frame 0x05, 0x5A, with the register map attached -> write_en_o high for exactly 3 cycles with addr_o=0x05 and write_data_o=0x5A; register 5 reads back 0x5A.
2. After reset, read frame 0x80 plus one dummy byte -> read_en_o high 3 cycles, addr_o=0x00, MISO returns 0xCC MSB-first; frame_err_o=0.
3. With SPI_CSR_AUTOINC_EN defined, write frame 0x7F, 0x11, 0x22 -> commits 0x11 to 0x7F then 0x22 to 0x00 (wrap). Without the macro, both commits target 0x7F and the final value is 0x22.
4. cs_n rises after 4 bits of the data byte following command 0x03 -> no write_en_o pulse, frame_err_o=1, FSM back in IDLE; the next valid frame succeeds.
5. rst_i asserted mid read-shift of a 0xA5 byte -> all outputs 0 on the next cycle; the following frame (write 0x10, 0x33) commits correctly.
6. cs_n rises during WR_COMMIT cycle 1 -> write_en_o still held 3 cycles, the register gets the data, frame_err_o stays 0.
